fft_frame_loader: RTL and testbench
===================================

Name: fft_frame_loader

Overview:
- Upstream stage of the fft core. Accepts a streaming complex sample interface (valid/ready) and assembles N-sample frames in two ping-pong banks.
- Optionally stores samples in bit-reversed order.
- Presents a complete frame on flat buses for the FFT's parallel x_r/x_i inputs, with a valid/ack handshake, so input streaming continues while the FFT consumes the other bank.

Parameters:
- WIDTH, 32, bits per real/imag component (signed, Q1.31 for the default).
- N, 8, points per frame (power of two).
- LOG2N, 3, log2(N); sample index width.
- BIT_REV, 0, 1 = sample n stored at slot bitrev(n); 0 = natural order.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  sample present on in_r/in_i.
- in_ready  out  1  loader can accept a sample this cycle.
- in_r  in  WIDTH  signed real part of the sample.
- in_i  in  WIDTH  signed imaginary part of the sample.
- in_sof  in  1  start-of-frame marker, qualified by in_valid&&in_ready.
- frame_valid  out  1  complete frame held on frame_r/frame_i.
- frame_ack  in  1  consumer has taken the frame; releases the bank.
- frame_r  out  N*WIDTH  real parts, slot k at [k*WIDTH +: WIDTH].
- frame_i  out  N*WIDTH  imaginary parts, same packing.
- frame_err  out  1  one-cycle pulse: partial frame discarded by in_sof.
- frame_count  out  16  frames completed since reset, wraps 0xFFFF->0.

Behaviour:
- State: two banks (bank 0, bank 1), each N complex registers plus a full flag. Also wr_bank, rd_bank, and wr_idx[LOG2N-1:0].
- Reset (async, rst=1): full flags=0, wr_bank=rd_bank=0, wr_idx=0, all bank data=0, frame_valid=0, in_ready=0, frame_err=0, frame_count=0. frame_r/frame_i read 0.
- in_ready = !rst && !full[wr_bank], derived combinationally from registered state.
- Accept occurs when in_valid&&in_ready at the rising edge.
- Write address is BIT_REV ? bitrev(wr_idx) : wr_idx. If in_sof is set on the accepted beat, the address uses index 0.
- in_sof on an accepted beat with wr_idx!=0: discard the partial frame, write the sample at index 0, set wr_idx=1, and pulse frame_err the next cycle. in_sof with wr_idx==0 is normal.
- Accept at index N-1 (effective index after any sof handling; N=1 excluded): set full[wr_bank], toggle wr_bank, set wr_idx=0, increment frame_count.
- Data is stored unmodified (no scaling or saturation); the bank does not alter bits.
- Output side: frame_valid = full[rd_bank]. frame_r/frame_i are a mux of the rd_bank registers.
- Latency: frame_valid rises in the cycle after the edge that accepts the last sample. Minimum gap from last sample to frame_valid is 1 cycle.
- Handshake: the frame holds bit-stable while frame_valid && !frame_ack. With frame_valid && frame_ack at an edge, clear full[rd_bank] and toggle rd_bank. The next bank's frame appears the following cycle if it is full.
- frame_ack while frame_valid=0 is ignored.
- Simultaneous completion (write bank) and ack (read bank) in one cycle: both take effect.
- Simultaneous completion and ack on the same bank cannot occur, because the write bank is never full while accepting.
- Both banks full: in_ready=0 and input stalls. After an ack, in_ready returns the next cycle.
- Throughput: 1 sample/cycle sustained if the consumer acks within N cycles of frame_valid.
- rst asserted mid-frame or mid-handshake: all partial and complete frames are lost; state returns to reset values immediately.

Test Plan:
- BIT_REV=0, in_r=n+1, in_i=-(n+1) for n=0..7 on consecutive cycles, no stalls. Required: frame_valid rises 1 cycle after the 8th accept; slot k holds (k+1, -(k+1)); frame_count=1.
- BIT_REV=1, same stimulus. Required: slots 0..7 real = 1,5,3,7,2,6,4,8.
- Load the unit-circle set: real 2147483647, 1518500249, 0, -1518500249, -2147483647, -1518500249, 0, 1518500249 with matching sin values. Required: bit-exact storage, including negatives.
- No frame_ack, drive in_valid=1 continuously for 24 cycles. Required: 16 accepts, then in_ready=0. frame_valid holds bank 0 data stable. frame_ack for one cycle -> bank 1 data next cycle, in_ready=1, frame_count=2, and accepting resumes.
- Three samples accepted, then in_sof with in_r=100 followed by 7 more samples. Required: frame_err pulse once; the emitted frame slot 0 = 100; frame_count=1.
- Assert rst asynchronously (between edges) after 5 samples with one full frame pending. Required: frame_valid=0 and in_ready=0 immediately. After release: frame_count=0, and the next 8 samples form a clean frame in bank 0.

Source files
------------

// File: rtl/fft_frame_loader.sv
// -----------------------------------------------------------------------------
// fft_frame_loader
//
// Upstream stage of the FFT core. Collects a valid/ready stream of complex
// samples into N-sample frames using two ping-pong banks. A completed bank is
// presented in parallel on frame_r/frame_i with a valid/ack handshake. While
// the consumer works on one bank, the stream keeps filling the other bank.
//
// Parameters
//   WIDTH   bits per real/imag component (signed)
//   N       points per frame (power of two, N > 1)
//   LOG2N   log2(N), the width of the sample index
//   BIT_REV 1: sample n is stored at slot bitrev(n); 0: natural order
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   in_valid      a sample is present on in_r/in_i/in_sof
//   in_ready      the loader accepts the sample at this edge
//   in_r, in_i    signed sample components
//   in_sof        start of frame, qualified by an accepted beat
//   frame_valid   a complete frame is held on frame_r/frame_i
//   frame_ack     the consumer has taken the frame; frees the bank
//   frame_r/_i    slot k at [k*WIDTH +: WIDTH]
//   frame_err     one-cycle pulse when in_sof discards a partial frame
//   frame_count   number of frames completed since reset (wraps)
// -----------------------------------------------------------------------------
module fft_frame_loader #(
    parameter int WIDTH   = 32,
    parameter int N       = 8,
    parameter int LOG2N   = 3,
    parameter int BIT_REV = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [WIDTH-1:0]   in_r,
    input  logic signed [WIDTH-1:0]   in_i,
    input  logic                      in_sof,
    output logic                      frame_valid,
    input  logic                      frame_ack,
    output logic [N*WIDTH-1:0]        frame_r,
    output logic [N*WIDTH-1:0]        frame_i,
    output logic                      frame_err,
    output logic [15:0]               frame_count
);

    // Reverse the bit order of a sample index.
    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int b = 0; b < LOG2N; b++) begin
            r[b] = v[LOG2N-1-b];
        end
        return r;
    endfunction

    // Two banks of N complex registers.
    logic signed [WIDTH-1:0] bank_r [2][N];
    logic signed [WIDTH-1:0] bank_i [2][N];

    logic [1:0]       full;
    logic [1:0]       full_nxt;
    logic             wr_bank;
    logic             rd_bank;
    logic [LOG2N-1:0] wr_idx;

    logic             accept;
    logic             ack_take;
    logic             sof_restart;
    logic             last_beat;
    logic [LOG2N-1:0] eff_idx;
    logic [LOG2N-1:0] wr_addr;

    // The write bank can only be full when both banks are full, which is
    // exactly the stall condition.
    assign in_ready    = !rst && !full[wr_bank];
    assign frame_valid = full[rd_bank];

    assign accept   = in_valid && in_ready;
    assign ack_take = frame_valid && frame_ack;

    // A start-of-frame beat always lands at index 0; if a partial frame was
    // in progress it is abandoned and the new frame restarts from here.
    assign eff_idx     = in_sof ? '0 : wr_idx;
    assign sof_restart = accept && in_sof && (wr_idx != '0);
    assign last_beat   = (eff_idx == LOG2N'(N-1));
    assign wr_addr     = (BIT_REV != 0) ? bitrev(eff_idx) : eff_idx;

    // Completion and release touch different banks, so both may apply in
    // the same cycle without conflict.
    always_comb begin
        full_nxt = full;
        if (ack_take) begin
            full_nxt[rd_bank] = 1'b0;
        end
        if (accept && last_beat) begin
            full_nxt[wr_bank] = 1'b1;
        end
    end

    // ---- write side: index, bank pointers, counters ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full        <= 2'b00;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            wr_idx      <= '0;
            frame_err   <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            full      <= full_nxt;
            frame_err <= sof_restart;
            if (ack_take) begin
                rd_bank <= ~rd_bank;
            end
            if (accept) begin
                if (last_beat) begin
                    wr_bank     <= ~wr_bank;
                    wr_idx      <= '0;
                    frame_count <= frame_count + 16'd1;
                end else begin
                    wr_idx <= eff_idx + LOG2N'(1);
                end
            end
        end
    end

    // ---- bank storage: samples are kept bit-exact ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < N; k++) begin
                    bank_r[b][k] <= '0;
                    bank_i[b][k] <= '0;
                end
            end
        end else if (accept) begin
            bank_r[wr_bank][wr_addr] <= in_r;
            bank_i[wr_bank][wr_addr] <= in_i;
        end
    end

    // ---- read side: present the read bank as flat buses ----
    always_comb begin
        frame_r = '0;
        frame_i = '0;
        for (int k = 0; k < N; k++) begin
            frame_r[k*WIDTH +: WIDTH] = bank_r[rd_bank][k];
            frame_i[k*WIDTH +: WIDTH] = bank_i[rd_bank][k];
        end
    end

endmodule

// File: tb/tb_fft_frame_loader.sv
module tb_fft_frame_loader;

    localparam int W     = 32;
    localparam int N     = 8;
    localparam int LOG2N = 3;
    localparam int NW    = N * W;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_sof;
    logic [W-1:0]  in_r;
    logic [W-1:0]  in_i;
    logic          frame_ack;

    logic          rdy0, rdy1, fv0, fv1, err0, err1;
    logic [NW-1:0] fr0, fi0, fr1, fi1;
    logic [15:0]   cnt0, cnt1;

    fft_frame_loader #(.WIDTH(W), .N(N), .LOG2N(LOG2N), .BIT_REV(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
        .in_r(in_r), .in_i(in_i), .in_sof(in_sof),
        .frame_valid(fv0), .frame_ack(frame_ack),
        .frame_r(fr0), .frame_i(fi0), .frame_err(err0), .frame_count(cnt0)
    );

    fft_frame_loader #(.WIDTH(W), .N(N), .LOG2N(LOG2N), .BIT_REV(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
        .in_r(in_r), .in_i(in_i), .in_sof(in_sof),
        .frame_valid(fv1), .frame_ack(frame_ack),
        .frame_r(fr1), .frame_i(fi1), .frame_err(err1), .frame_count(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [NW-1:0] obs, input logic [NW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [NW-1:0] q_r[$];
    logic [NW-1:0] q_i[$];
    logic [NW-1:0] part_r, part_i;
    int            part_n;
    logic [15:0]   exp_count;
    bit            exp_err;

    function automatic int brev(input int k);
        int r;
        r = 0;
        for (int b = 0; b < LOG2N; b++) r = r * 2 + ((k >> b) & 1);
        return r;
    endfunction

    // Slot k of the bit-reversed bank holds sample brev(k).
    function automatic logic [NW-1:0] perm(input logic [NW-1:0] f);
        logic [NW-1:0] p;
        p = '0;
        for (int k = 0; k < N; k++) p[k*W +: W] = f[brev(k)*W +: W];
        return p;
    endfunction

    task automatic model_reset();
        q_r.delete();
        q_i.delete();
        part_r = '0;
        part_i = '0;
        part_n = 0;
        exp_count = 16'd0;
        exp_err = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic sof, input logic [W-1:0] r,
                              input logic [W-1:0] i, input logic ack);
        bit rdy;
        bit ackd;
        rdy  = (q_r.size() < 2);
        ackd = ack && (q_r.size() > 0);
        exp_err = 1'b0;
        if (ackd) begin
            void'(q_r.pop_front());
            void'(q_i.pop_front());
        end
        if (v && rdy) begin
            if (sof) begin
                if (part_n != 0) exp_err = 1'b1;
                part_n = 0;
            end
            part_r[part_n*W +: W] = r;
            part_i[part_n*W +: W] = i;
            part_n++;
            if (part_n == N) begin
                q_r.push_back(part_r);
                q_i.push_back(part_i);
                exp_count = exp_count + 16'd1;
                part_n = 0;
            end
        end
    endtask

    task automatic compare_outputs();
        bit ev;
        ev = (q_r.size() > 0);
        check("in_ready0", NW'(rdy0), NW'(q_r.size() < 2));
        check("in_ready1", NW'(rdy1), NW'(q_r.size() < 2));
        check("frame_valid0", NW'(fv0), NW'(ev));
        check("frame_valid1", NW'(fv1), NW'(ev));
        check("frame_err0", NW'(err0), NW'(exp_err));
        check("frame_err1", NW'(err1), NW'(exp_err));
        check("frame_count0", NW'(cnt0), NW'(exp_count));
        check("frame_count1", NW'(cnt1), NW'(exp_count));
        if (ev) begin
            check("frame_r_nat", fr0, q_r[0]);
            check("frame_i_nat", fi0, q_i[0]);
            check("frame_r_rev", fr1, perm(q_r[0]));
            check("frame_i_rev", fi1, perm(q_i[0]));
        end
    endtask

    // One clock cycle: drive just after the edge, compare mid-cycle, then
    // advance the model with what was present at the edge.
    task automatic cycle(input logic v, input logic sof, input logic [W-1:0] r,
                         input logic [W-1:0] i, input logic ack);
        in_valid = v; in_sof = sof; in_r = r; in_i = i; frame_ack = ack;
        @(negedge clk);
        compare_outputs();
        @(posedge clk);
        model_step(v, sof, r, i, ack);
        #1;
    endtask

    task automatic idle(input logic ack);
        cycle(1'b0, 1'b0, '0, '0, ack);
    endtask

    int unit_r[N] = '{2147483647, 1518500249, 0, -1518500249, -2147483647, -1518500249, 0, 1518500249};
    int unit_i[N] = '{0, 1518500249, 2147483647, 1518500249, 0, -1518500249, -2147483647, -1518500249};
    int rev_r[N]  = '{1, 5, 3, 7, 2, 6, 4, 8};

    initial begin
        logic [NW-1:0] v_a, v_b;

        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_r = '0; in_i = '0; frame_ack = 1'b0;
        model_reset();
        #1;
        check("rst_in_ready", NW'(rdy0), NW'(0));
        check("rst_frame_valid", NW'(fv0), NW'(0));
        check("rst_frame_r", fr0, '0);
        check("rst_frame_i", fi1, '0);
        check("rst_count", NW'(cnt0), NW'(0));
        check("rst_err", NW'(err0), NW'(0));
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Natural and bit-reversed ordering of a ramp.
        for (int n = 0; n < N; n++) cycle(1'b1, n == 0, W'(n + 1), W'(-(n + 1)), 1'b0);
        idle(1'b0);
        v_a = '0; v_b = '0;
        for (int k = 0; k < N; k++) begin
            v_a[k*W +: W] = W'(k + 1);
            v_b[k*W +: W] = W'(rev_r[k]);
        end
        check("ramp_nat_r", fr0, v_a);
        check("ramp_rev_r", fr1, v_b);
        check("ramp_count", NW'(cnt0), NW'(1));
        idle(1'b1);

        // Unit-circle values, including full-scale negatives.
        for (int n = 0; n < N; n++) cycle(1'b1, 1'b0, W'(unit_r[n]), W'(unit_i[n]), 1'b0);
        idle(1'b0);
        for (int k = 0; k < N; k++) begin
            v_a[k*W +: W] = W'(unit_r[k]);
            v_b[k*W +: W] = W'(unit_i[k]);
        end
        check("unit_r", fr0, v_a);
        check("unit_i", fi0, v_b);
        idle(1'b1);

        // Continuous input with no ack: both banks fill, then stall.
        for (int c = 0; c < 24; c++) cycle(1'b1, 1'b0, W'($urandom), W'($urandom), 1'b0);
        check("stall_ready", NW'(rdy0), NW'(0));
        cycle(1'b1, 1'b0, W'($urandom), W'($urandom), 1'b1);
        check("resume_ready", NW'(rdy0), NW'(1));
        check("resume_count", NW'(cnt0), NW'(4));
        for (int c = 0; c < 4; c++) cycle(1'b1, 1'b0, W'($urandom), W'($urandom), 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);

        // in_sof in the middle of a frame restarts it.
        for (int n = 0; n < N; n++) cycle(1'b1, 1'b0, W'(n + 10), W'(n), 1'b0);
        idle(1'b1);
        for (int n = 0; n < 3; n++) cycle(1'b1, n == 0, W'(n + 50), W'(n), 1'b0);
        cycle(1'b1, 1'b1, W'(100), W'(7), 1'b0);
        for (int n = 0; n < 7; n++) cycle(1'b1, 1'b0, W'(n + 200), W'(n), 1'b0);
        idle(1'b0);
        check("sof_slot0", NW'(fr0[W-1:0]), NW'(100));
        idle(1'b1);

        // Asynchronous reset with one full frame and a partial frame held.
        for (int n = 0; n < N + 5; n++) cycle(1'b1, 1'b0, W'($urandom), W'($urandom), 1'b0);
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check("arst_valid", NW'(fv0), NW'(0));
        check("arst_ready", NW'(rdy1), NW'(0));
        check("arst_count", NW'(cnt0), NW'(0));
        model_reset();
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        for (int n = 0; n < N; n++) cycle(1'b1, 1'b0, W'($urandom), W'($urandom), 1'b0);
        idle(1'b0);
        idle(1'b1);

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
                  W'($urandom), W'($urandom), ($urandom_range(0, 1) == 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
